// File: rtl/tri_pkg.sv
// Shared types and constants for the triangle-wave sweep sequencer.
package tri_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GOT_LO  = 2'd1,
    PENDING = 2'd2
  } cfg_state_t;

  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic       DIR_UP   = 1'b1;
  localparam logic       DIR_DOWN = 1'b0;

  function automatic logic is_bcd(input logic [3:0] d);
    return d <= BCD_MAX;
  endfunction

endpackage

// File: rtl/tri_tick_gen.sv
// Free-running divider producing a one-cycle tick every DIV clocks (DIV >= 2).
module tri_tick_gen #(
  parameter int DIV   = 4,
  parameter int CNT_W = $clog2(DIV)
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  logic [CNT_W-1:0] div;

  // The tick flop is armed one count early so it is high exactly while div == DIV-1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div  <= '0;
      tick <= 1'b0;
    end else begin
      if (div == CNT_W'(DIV - 1)) div <= '0;
      else                        div <= div + CNT_W'(1);
      tick <= (div == CNT_W'(DIV - 2));
    end
  end

endmodule

// File: rtl/tri_sweep_ctrl.sv
// Sequencer for the triangle-wave BCD counter: limit loading, direction and step timing.
// New limits are taken over only at a turning point so the counter never sees a glitch.
module tri_sweep_ctrl
  import tri_pkg::*;
#(
  parameter int DIV   = 25_000_000,
  parameter int CNT_W = $clog2(DIV)
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       push,
  input  logic [3:0] din,
  input  logic [3:0] value,
  output logic       cen,
  output logic       dir,
  output logic [3:0] limitl,
  output logic [3:0] limith,
  output logic [1:0] cfg_state,
  output logic       err
);

  logic       rst_meta_n;
  logic       rst_sync_n;
  logic       tick;
  logic       push_q;
  logic [3:0] pend_lo;
  logic [3:0] pend_hi;
  cfg_state_t state;

  logic push_rise;
  logic din_ok;
  logic load;
  logic hold;
  logic at_turn;
  logic apply;

  // NOTE: assertion is asynchronous, release is re-timed through two flops to avoid recovery races.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rst_meta_n <= 1'b0;
      rst_sync_n <= 1'b0;
    end else begin
      rst_meta_n <= 1'b1;
      rst_sync_n <= rst_meta_n;
    end
  end

  tri_tick_gen #(
    .DIV   (DIV),
    .CNT_W (CNT_W)
  ) u_tick (
    .clk     (clk),
    .reset_n (rst_sync_n),
    .tick    (tick)
  );

  assign push_rise = push & ~push_q;
  assign din_ok    = is_bcd(din);
  assign load      = push_rise & din_ok;

  // Equal limits with the counter sitting on them: freeze the wave.
  assign hold    = (limitl == limith) && (value == limitl);
  assign at_turn = ((dir == DIR_UP)   && (value >= limith)) ||
                   ((dir == DIR_DOWN) && (value <= limitl)) ||
                   hold;
  // Avoid the tick cycle so a limit change never coincides with a cen launch.
  assign apply   = (state == PENDING) && at_turn && !tick;

  assign cfg_state = state;

  // NOTE: every register here uses <= so all updates see the pre-edge values of each other.
  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      push_q  <= 1'b0;
      state   <= IDLE;
      pend_lo <= '0;
      pend_hi <= '0;
      limitl  <= '0;
      limith  <= BCD_MAX;
      dir     <= DIR_UP;
      cen     <= 1'b0;
      err     <= 1'b0;
    end else begin
      push_q <= push;
      err    <= push_rise & ~din_ok;
      cen    <= tick & ~hold;

      if (!hold) begin
        if ((dir == DIR_UP) && (value >= limith))        dir <= DIR_DOWN;
        else if ((dir == DIR_DOWN) && (value <= limitl)) dir <= DIR_UP;
      end

      // NOTE: the default arm keeps the decode full; unlisted encodings recover to IDLE.
      unique case (state)
        IDLE: begin
          if (load) begin
            pend_lo <= din;
            state   <= GOT_LO;
          end
        end
        GOT_LO: begin
          if (load) begin
            if (pend_lo > din) begin
              pend_lo <= din;
              pend_hi <= pend_lo;
            end else begin
              pend_hi <= din;
            end
            state <= PENDING;
          end
        end
        PENDING: begin
          // Apply takes priority; a push in the same cycle is consumed.
          if (apply) begin
            limitl <= pend_lo;
            limith <= pend_hi;
            state  <= IDLE;
          end else if (load) begin
            pend_lo <= din;
            state   <= GOT_LO;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tri_sweep_ctrl.sv
// Directed bench: tri_sweep_ctrl paired with a behavioural cnt_bcd, value steps checked from a scoreboard.
module tb_tri_sweep_ctrl;
  import tri_pkg::*;

  localparam int DIV = 4;

  logic       clk;
  logic       reset_n;
  logic       push;
  logic [3:0] din;
  logic [3:0] value;
  logic       cen;
  logic       dir;
  logic [3:0] limitl;
  logic [3:0] limith;
  logic [1:0] cfg_state;
  logic       err;

  int         checks = 0;
  int         errors = 0;
  int         cyc    = 0;
  logic [3:0] sb[$];
  logic       cen_prev = 1'b0;

  tri_sweep_ctrl #(.DIV(DIV)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .din       (din),
    .value     (value),
    .cen       (cen),
    .dir       (dir),
    .limitl    (limitl),
    .limith    (limith),
    .cfg_state (cfg_state),
    .err       (err)
  );

  // Behavioural cnt_bcd: saturating BCD up/down counter stepped by cen.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                    value <= 4'd0;
    else if (cen) begin
      if (dir && value < 4'd9)       value <= value + 4'd1;
      else if (!dir && value > 4'd0) value <= value - 4'd1;
    end
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Every step the counter takes must match the next queued expectation.
  always @(negedge clk) begin
    if (!reset_n) begin
      cen_prev = 1'b0;
    end else begin
      if (cen_prev) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL sb_unexpected_step observed=%0d expected=no_step", value);
        end else begin
          check("sb_value", 32'(value), 32'(sb.pop_front()));
        end
      end
      cen_prev = cen;
    end
  end

  task automatic ramp(input int a, input int b);
    if (a <= b) for (int i = a; i <= b; i++) sb.push_back(4'(i));
    else        for (int i = a; i >= b; i--) sb.push_back(4'(i));
  endtask

  task automatic wait_value(input logic [3:0] v, input int max, input string tag);
    for (int i = 0; i < max; i++) begin
      if (value == v) return;
      @(negedge clk);
    end
    checks++;
    errors++;
    $error("FAIL %s observed=timeout expected=value_%0d", tag, v);
  endtask

  task automatic wait_cen(input int max, input string tag);
    for (int i = 0; i < max; i++) begin
      if (cen) return;
      @(negedge clk);
    end
    checks++;
    errors++;
    $error("FAIL %s observed=timeout expected=cen", tag);
  endtask

  task automatic do_push(input logic [3:0] d, output logic err_seen);
    din  = d;
    push = 1'b1;
    @(negedge clk);
    err_seen = err;
    push = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=stuck expected=finish");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    logic e;
    int   c0, c1, n;

    reset_n = 1'b0;
    push    = 1'b0;
    din     = 4'd0;
    repeat (3) @(negedge clk);
    check("rst_limitl", 32'(limitl), 0);
    check("rst_limith", 32'(limith), 9);
    check("rst_dir", 32'(dir), 1);
    check("rst_cen", 32'(cen), 0);
    check("rst_err", 32'(err), 0);
    check("rst_cfg", 32'(cfg_state), 0);

    ramp(1, 9); ramp(8, 0);
    ramp(1, 9); ramp(8, 2); ramp(3, 6);
    ramp(5, 3); ramp(4, 5);
    reset_n = 1'b1;

    // Free sweep: cen period and turning points.
    wait_cen(12, "first_cen");
    c0 = cyc;
    @(negedge clk);
    check("cen_one_cycle", 32'(cen), 0);
    wait_cen(12, "second_cen");
    c1 = cyc;
    check("cen_period", 32'(c1 - c0), DIV);
    wait_value(4'd9, 100, "reach_9");
    check("dir_at_9", 32'(dir), 1);
    @(negedge clk);
    check("dir_after_9", 32'(dir), 0);
    wait_value(4'd0, 100, "reach_0");
    check("dir_at_0", 32'(dir), 0);
    @(negedge clk);
    check("dir_after_0", 32'(dir), 1);

    // Load 2/6 while rising; applied at the old top.
    wait_value(4'd4, 40, "reach_4");
    do_push(4'd2, e);
    check("p2_err", 32'(e), 0);
    check("p2_cfg", 32'(cfg_state), 1);
    do_push(4'd6, e);
    check("p6_cfg", 32'(cfg_state), 2);
    wait_value(4'd9, 60, "reach_9_apply");
    check("pre_apply_limith", 32'(limith), 9);
    @(negedge clk);
    check("a1_limitl", 32'(limitl), 2);
    check("a1_limith", 32'(limith), 6);
    check("a1_dir", 32'(dir), 0);
    check("a1_cfg", 32'(cfg_state), 0);

    // Swapped entry 7 then 3 at the bottom; applied at the next top.
    wait_value(4'd2, 60, "reach_2");
    do_push(4'd7, e);
    check("p7_cfg", 32'(cfg_state), 1);
    do_push(4'd3, e);
    check("p3_cfg", 32'(cfg_state), 2);
    wait_value(4'd6, 60, "reach_6");
    check("pre_a2_limitl", 32'(limitl), 2);
    @(negedge clk);
    check("a2_limitl", 32'(limitl), 3);
    check("a2_limith", 32'(limith), 7);
    check("a2_dir", 32'(dir), 0);

    // Invalid digit in IDLE, then in GOT_LO while entering 5/5.
    do_push(4'hA, e);
    check("errA_idle_pulse", 32'(e), 1);
    check("errA_idle_clear", 32'(err), 0);
    check("errA_idle_cfg", 32'(cfg_state), 0);
    check("errA_idle_limitl", 32'(limitl), 3);
    check("errA_idle_limith", 32'(limith), 7);
    do_push(4'd5, e);
    check("p5a_cfg", 32'(cfg_state), 1);
    do_push(4'hB, e);
    check("errB_gotlo_pulse", 32'(e), 1);
    check("errB_gotlo_cfg", 32'(cfg_state), 1);
    do_push(4'd5, e);
    check("p5b_err", 32'(e), 0);
    check("p5b_cfg", 32'(cfg_state), 2);
    wait_value(4'd3, 40, "reach_3");
    @(negedge clk);
    check("a3_limitl", 32'(limitl), 5);
    check("a3_limith", 32'(limith), 5);
    check("a3_dir", 32'(dir), 1);

    // Hold at 5, then 1/8 applied from the hold.
    wait_value(4'd5, 40, "reach_5");
    n = 0;
    repeat (12) begin
      @(negedge clk);
      if (cen) n++;
    end
    check("hold_no_cen", 32'(n), 0);
    check("hold_value", 32'(value), 5);
    ramp(6, 6);
    do_push(4'd1, e);
    do_push(4'd8, e);
    wait_value(4'd5, 1, "hold_still_5");
    for (int i = 0; i < 4 && limitl != 4'd1; i++) @(negedge clk);
    check("a4_limitl", 32'(limitl), 1);
    check("a4_limith", 32'(limith), 8);
    check("a4_cfg", 32'(cfg_state), 0);
    wait_cen(6, "resume_cen");

    // Reset while PENDING: asynchronous clear, pending values lost.
    do_push(4'd2, e);
    do_push(4'd3, e);
    check("p23_cfg", 32'(cfg_state), 2);
    #2 reset_n = 1'b0;
    #1;
    check("arst_cen", 32'(cen), 0);
    check("arst_dir", 32'(dir), 1);
    check("arst_limitl", 32'(limitl), 0);
    check("arst_limith", 32'(limith), 9);
    check("arst_cfg", 32'(cfg_state), 0);
    check("arst_err", 32'(err), 0);
    sb.delete();
    ramp(1, 9); ramp(8, 8);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    wait_value(4'd9, 100, "post_rst_9");
    check("post_rst_dir", 32'(dir), 1);
    @(negedge clk);
    check("post_rst_limitl", 32'(limitl), 0);
    check("post_rst_limith", 32'(limith), 9);
    check("post_rst_cfg", 32'(cfg_state), 0);
    check("post_rst_dir_fall", 32'(dir), 0);
    wait_value(4'd8, 20, "post_rst_8");
    @(negedge clk);
    check("sb_drained", 32'(sb.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
